// File: rtl/fp_minmax_cmp_pipe_if.sv
// ---------------------------------------------------------------------------
// fp_minmax_cmp_pipe_if
// Request/response bundle for the floating-point min/max/compare unit.
//
// Request side  : in_valid, in_ready, in_a, in_b, in_op, in_tag
// Response side : out_valid, out_ready, out_result, out_nv, out_tag
//
// master : the client that issues operations and consumes results
// slave  : the unit that executes them
// ---------------------------------------------------------------------------
interface fp_minmax_cmp_pipe_if #(
    parameter int FLEN  = 64,
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [FLEN-1:0]  in_a;
    logic [FLEN-1:0]  in_b;
    logic [2:0]       in_op;
    logic [TAG_W-1:0] in_tag;

    logic             out_valid;
    logic             out_ready;
    logic [FLEN-1:0]  out_result;
    logic             out_nv;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_a, in_b, in_op, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_nv, out_tag
    );

    modport slave (
        input  in_valid, in_a, in_b, in_op, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_nv, out_tag
    );
endinterface

// File: rtl/fp_minmax_cmp_pipe.sv
// ---------------------------------------------------------------------------
// fp_minmax_cmp_pipe
// Pipelined IEEE-754 FMIN / FMAX / FEQ / FLT / FLE unit with RISC-V NaN and
// signed-zero semantics and the NV exception flag. Width is set by EXP_W and
// MAN_W; the pipeline is LAT register stages deep (1..4) with a valid/ready
// elastic handshake and a tag that rides along with each operation.
//
// Ports
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : fp_minmax_cmp_pipe_if.slave
//            in_valid/in_ready/in_a/in_b/in_op/in_tag   request
//            out_valid/out_ready/out_result/out_nv/out_tag response
//   in_op  : 0 MIN, 1 MAX, 2 FEQ, 3 FLT, 4 FLE, 5-7 reserved (result 0, nv 0)
// ---------------------------------------------------------------------------
module fp_minmax_cmp_pipe #(
    parameter int EXP_W = 11,
    parameter int MAN_W = 52,
    parameter int LAT   = 2,
    parameter int TAG_W = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    fp_minmax_cmp_pipe_if.slave bus
);
    localparam int FLEN = 1 + EXP_W + MAN_W;

    // Canonical quiet NaN: positive, exponent all ones, only the quiet bit set.
    localparam logic [FLEN-1:0] CANON_NAN =
        {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [2:0] {
        OP_MIN = 3'd0,
        OP_MAX = 3'd1,
        OP_FEQ = 3'd2,
        OP_FLT = 3'd3,
        OP_FLE = 3'd4
    } op_e;

    // ---------------- operand classification ----------------
    logic             a_sign, b_sign;
    logic [EXP_W-1:0] a_exp, b_exp;
    logic [MAN_W-1:0] a_man, b_man;
    logic [FLEN-2:0]  a_mag, b_mag;
    logic             a_nan, b_nan, a_snan, b_snan, a_zero, b_zero;
    logic             any_nan, any_snan, both_zero, raw_eq, a_lt_b;
    logic             feq_bit, flt_bit, fle_bit;

    assign a_sign = bus.in_a[FLEN-1];
    assign b_sign = bus.in_b[FLEN-1];
    assign a_exp  = bus.in_a[FLEN-2:MAN_W];
    assign b_exp  = bus.in_b[FLEN-2:MAN_W];
    assign a_man  = bus.in_a[MAN_W-1:0];
    assign b_man  = bus.in_b[MAN_W-1:0];
    assign a_mag  = bus.in_a[FLEN-2:0];
    assign b_mag  = bus.in_b[FLEN-2:0];

    assign a_nan  = (&a_exp) && (|a_man);
    assign b_nan  = (&b_exp) && (|b_man);
    assign a_snan = a_nan && !a_man[MAN_W-1];
    assign b_snan = b_nan && !b_man[MAN_W-1];
    assign a_zero = (a_exp == '0) && (a_man == '0);
    assign b_zero = (b_exp == '0) && (b_man == '0);

    assign any_nan   = a_nan || b_nan;
    assign any_snan  = a_snan || b_snan;
    assign both_zero = a_zero && b_zero;
    assign raw_eq    = (bus.in_a == bus.in_b);

    // Sign-magnitude ordering on raw bits. With differing signs the negative
    // operand is smaller, which also makes -0 < +0 as MIN/MAX require. For two
    // negatives the larger magnitude is the smaller number.
    assign a_lt_b = (a_sign != b_sign) ? a_sign :
                    (a_sign ? (a_mag > b_mag) : (a_mag < b_mag));

    // Compares treat the two zeros as equal, so the zero case is patched in
    // on top of the raw ordering.
    assign feq_bit = !any_nan && (raw_eq || both_zero);
    assign flt_bit = !any_nan && !both_zero && a_lt_b;
    assign fle_bit = !any_nan && (raw_eq || both_zero || a_lt_b);

    // ---------------- stage 0 result selection ----------------
    logic [FLEN-1:0] s0_result;
    logic            s0_nv;

    // Pick the result and NV flag for the requested op. MIN/MAX drop a single
    // NaN in favour of the other operand; FLT/FLE signal on any NaN while
    // MIN/MAX/FEQ signal only on a signaling NaN. Reserved ops give zero.
    always_comb begin
        s0_result = '0;
        s0_nv     = 1'b0;
        case (bus.in_op)
            OP_MIN: begin
                s0_nv = any_snan;
                if (a_nan && b_nan)  s0_result = CANON_NAN;
                else if (a_nan)      s0_result = bus.in_b;
                else if (b_nan)      s0_result = bus.in_a;
                else                 s0_result = a_lt_b ? bus.in_a : bus.in_b;
            end
            OP_MAX: begin
                s0_nv = any_snan;
                if (a_nan && b_nan)  s0_result = CANON_NAN;
                else if (a_nan)      s0_result = bus.in_b;
                else if (b_nan)      s0_result = bus.in_a;
                else                 s0_result = a_lt_b ? bus.in_b : bus.in_a;
            end
            OP_FEQ: begin
                s0_nv     = any_snan;
                s0_result = {{(FLEN-1){1'b0}}, feq_bit};
            end
            OP_FLT: begin
                s0_nv     = any_nan;
                s0_result = {{(FLEN-1){1'b0}}, flt_bit};
            end
            OP_FLE: begin
                s0_nv     = any_nan;
                s0_result = {{(FLEN-1){1'b0}}, fle_bit};
            end
            default: begin
                s0_nv     = 1'b0;
                s0_result = '0;
            end
        endcase
    end

    // ---------------- elastic pipeline ----------------
    logic [LAT-1:0]   valid_q;
    logic [LAT-1:0]   nv_q;
    logic [LAT-1:0]   load;
    logic [FLEN-1:0]  result_q [LAT];
    logic [TAG_W-1:0] tag_q    [LAT];

    // A stage may load when the consumer takes the last stage this cycle or
    // when any stage from here to the output is empty (that bubble lets
    // everything in front of it shift). Written in closed form so there is
    // no ripple through the load vector itself.
    always_comb begin
        load = '0;
        for (int k = 0; k < LAT; k++) begin
            load[k] = bus.out_ready || ((valid_q >> k) != ({LAT{1'b1}} >> k));
        end
    end

    // Stage 0 captures the freshly computed result; later stages are plain
    // delay registers that only move when their load enable is high, which is
    // what keeps the output frozen while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            nv_q    <= '0;
            for (int k = 0; k < LAT; k++) begin
                result_q[k] <= '0;
                tag_q[k]    <= '0;
            end
        end else begin
            if (load[0]) begin
                valid_q[0]  <= bus.in_valid;
                nv_q[0]     <= s0_nv;
                result_q[0] <= s0_result;
                tag_q[0]    <= bus.in_tag;
            end
            for (int k = 1; k < LAT; k++) begin
                if (load[k]) begin
                    valid_q[k]  <= valid_q[k-1];
                    nv_q[k]     <= nv_q[k-1];
                    result_q[k] <= result_q[k-1];
                    tag_q[k]    <= tag_q[k-1];
                end
            end
        end
    end

    assign bus.in_ready   = load[0];
    assign bus.out_valid  = valid_q[LAT-1];
    assign bus.out_nv     = nv_q[LAT-1];
    assign bus.out_result = result_q[LAT-1];
    assign bus.out_tag    = tag_q[LAT-1];

endmodule

// File: tb/tb_fp_minmax_cmp_pipe.sv
// ---------------------------------------------------------------------------
// tb_fp_minmax_cmp_pipe
// Scoreboard bench for fp_minmax_cmp_pipe. One double-precision and one
// single-precision instance (both LAT=2) share clock and reset. Directed
// vectors push hand-computed expectations into a per-instance queue; a
// monitor on the falling edge pops and compares every delivered result and
// checks that stalled outputs hold steady.
// ---------------------------------------------------------------------------
module tb_fp_minmax_cmp_pipe;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    fp_minmax_cmp_pipe_if #(.FLEN(64), .TAG_W(5)) ifd ();
    fp_minmax_cmp_pipe_if #(.FLEN(32), .TAG_W(5)) ifs ();

    fp_minmax_cmp_pipe #(.EXP_W(11), .MAN_W(52), .LAT(2), .TAG_W(5)) dut_d (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifd)
    );

    fp_minmax_cmp_pipe #(.EXP_W(8), .MAN_W(23), .LAT(2), .TAG_W(5)) dut_s (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifs)
    );

    typedef struct packed {
        logic [63:0] res;
        logic        nv;
        logic [4:0]  tag;
    } exp_t;

    exp_t q_d[$];
    exp_t q_s[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    bit   rand_ready = 1'b0;
    bit   held_v [2];
    exp_t held   [2];

    localparam logic [2:0] MIN = 3'd0, MAX = 3'd1, FEQ = 3'd2, FLT = 3'd3, FLE = 3'd4;

    // Direct comparison of one observed value against a bench constant.
    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one op on the chosen instance (sp=1 single). Called and returns
    // 1 time unit after a rising edge; in_ready is sampled on the falling edge.
    task automatic apply_stimulus(input bit sp, input logic [2:0] op, input logic [63:0] a,
                                  input logic [63:0] b, input logic [4:0] tag,
                                  input logic [63:0] res, input logic nv, input bit push);
        bit accepted = 1'b0;
        int waits = 0;
        exp_t e;
        e = {res, nv, tag};
        if (push) begin
            if (sp) q_s.push_back(e);
            else    q_d.push_back(e);
        end
        if (sp) begin
            ifs.in_valid = 1'b1; ifs.in_a = a[31:0]; ifs.in_b = b[31:0];
            ifs.in_op = op; ifs.in_tag = tag;
        end else begin
            ifd.in_valid = 1'b1; ifd.in_a = a; ifd.in_b = b;
            ifd.in_op = op; ifd.in_tag = tag;
        end
        while (!accepted && waits < 200) begin
            @(negedge clk);
            accepted = sp ? ifs.in_ready : ifd.in_ready;
            @(posedge clk);
            #1;
            waits++;
        end
        ifd.in_valid = 1'b0;
        ifs.in_valid = 1'b0;
        if (!accepted) begin
            n_cmp++;
            n_fail++;
            $display("[TB] FAIL accept_timeout: tag %0d in_ready stayed 0 expected 1", tag);
        end
    endtask

    // Wait (bounded) for both scoreboards to empty.
    task automatic wait_drain(input string name);
        int n = 0;
        while ((q_d.size() != 0 || q_s.size() != 0) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (q_d.size() != 0 || q_s.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("[TB] FAIL %s: %0d/%0d results outstanding expected 0", name, q_d.size(), q_s.size());
        end
    endtask

    // One monitor step for instance sp: stability check while stalled, then
    // pop and compare when a result is handed over on the next rising edge.
    task automatic monitor_step(input int sp, input logic valid, input logic ready, input exp_t act);
        exp_t e;
        bit   have = 1'b0;
        if (!rst_n) begin
            held_v[sp] = 1'b0;
            return;
        end
        if (held_v[sp]) begin
            n_cmp++;
            if (!valid || act !== held[sp]) begin
                n_fail++;
                $display("[TB] FAIL stall_hold%0d: got v=%0b res=%h nv=%0b tag=%0d expected v=1 res=%h nv=%0b tag=%0d",
                         sp, valid, act.res, act.nv, act.tag, held[sp].res, held[sp].nv, held[sp].tag);
            end
        end
        if (valid && ready) begin
            held_v[sp] = 1'b0;
            n_cmp++;
            if (sp == 0 && q_d.size() != 0) begin have = 1'b1; e = q_d.pop_front(); end
            if (sp == 1 && q_s.size() != 0) begin have = 1'b1; e = q_s.pop_front(); end
            if (!have) begin
                n_fail++;
                $display("[TB] FAIL unexpected%0d: got res=%h tag=%0d expected no output", sp, act.res, act.tag);
            end else if (act !== e) begin
                n_fail++;
                $display("[TB] FAIL result%0d: got res=%h nv=%0b tag=%0d expected res=%h nv=%0b tag=%0d",
                         sp, act.res, act.nv, act.tag, e.res, e.nv, e.tag);
            end
        end else if (valid) begin
            held_v[sp] = 1'b1;
            held[sp]   = act;
        end else begin
            held_v[sp] = 1'b0;
        end
    endtask

    // Falling-edge monitor for both instances.
    always @(negedge clk) begin
        monitor_step(0, ifd.out_valid, ifd.out_ready, {ifd.out_result, ifd.out_nv, ifd.out_tag});
        monitor_step(1, ifs.out_valid, ifs.out_ready, {32'b0, ifs.out_result, ifs.out_nv, ifs.out_tag});
    end

    // Random back-pressure, only while rand_ready is set.
    always @(posedge clk) begin
        #1;
        if (rand_ready) begin
            ifd.out_ready = 1'($urandom_range(0, 1));
            ifs.out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        held_v[0] = 1'b0; held_v[1] = 1'b0;
        ifd.in_valid = 1'b0; ifd.in_a = '0; ifd.in_b = '0; ifd.in_op = '0; ifd.in_tag = '0;
        ifs.in_valid = 1'b0; ifs.in_a = '0; ifs.in_b = '0; ifs.in_op = '0; ifs.in_tag = '0;
        ifd.out_ready = 1'b1;
        ifs.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check_output("reset_out_valid", 64'(ifd.out_valid), 64'd0);
        check_output("reset_out_result", ifd.out_result, 64'd0);
        check_output("reset_out_nv_tag", {58'd0, ifd.out_nv, ifd.out_tag}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_output("in_ready_after_reset", 64'(ifd.in_ready), 64'd1);

        // First op: out_valid must rise on the second edge counting the accept edge.
        apply_stimulus(0, MIN, 64'h3FF0000000000000, 64'h4000000000000000, 5'd1, 64'h3FF0000000000000, 1'b0, 1'b1);
        check_output("latency_early", 64'(ifd.out_valid), 64'd0);
        @(posedge clk);
        #1;
        check_output("latency_on_time", 64'(ifd.out_valid), 64'd1);

        apply_stimulus(0, MAX, 64'h8000000000000000, 64'h0000000000000000, 5'd2, 64'h0000000000000000, 1'b0, 1'b1);
        apply_stimulus(0, MIN, 64'h0000000000000000, 64'h8000000000000000, 5'd3, 64'h8000000000000000, 1'b0, 1'b1);
        apply_stimulus(0, MIN, 64'h7FF4000000000000, 64'h4000000000000000, 5'd4, 64'h4000000000000000, 1'b1, 1'b1);
        apply_stimulus(0, MAX, 64'h7FF8000000000000, 64'h7FF8000000000000, 5'd5, 64'h7FF8000000000000, 1'b0, 1'b1);
        apply_stimulus(0, FLT, 64'h7FF8000000000000, 64'h3FF0000000000000, 5'd6, 64'd0, 1'b1, 1'b1);
        apply_stimulus(0, FEQ, 64'h7FF8000000000000, 64'h3FF0000000000000, 5'd7, 64'd0, 1'b0, 1'b1);
        apply_stimulus(0, FLE, 64'h8000000000000000, 64'h0000000000000000, 5'd8, 64'd1, 1'b0, 1'b1);
        apply_stimulus(0, FEQ, 64'h8000000000000000, 64'h0000000000000000, 5'd9, 64'd1, 1'b0, 1'b1);
        apply_stimulus(0, FLT, 64'h8000000000000000, 64'h0000000000000000, 5'd10, 64'd0, 1'b0, 1'b1);
        apply_stimulus(0, FLT, 64'h3FF0000000000000, 64'h4000000000000000, 5'd11, 64'd1, 1'b0, 1'b1);
        apply_stimulus(0, FLE, 64'h4000000000000000, 64'h3FF0000000000000, 5'd12, 64'd0, 1'b0, 1'b1);
        apply_stimulus(0, MAX, 64'hBFF0000000000000, 64'hC000000000000000, 5'd13, 64'hBFF0000000000000, 1'b0, 1'b1);
        apply_stimulus(0, MIN, 64'hBFF0000000000000, 64'hC000000000000000, 5'd14, 64'hC000000000000000, 1'b0, 1'b1);
        apply_stimulus(0, MIN, 64'h4000000000000000, 64'h7FF8000000000000, 5'd15, 64'h4000000000000000, 1'b0, 1'b1);
        apply_stimulus(0, FEQ, 64'h7FF4000000000000, 64'h3FF0000000000000, 5'd16, 64'd0, 1'b1, 1'b1);
        apply_stimulus(0, 3'd5, 64'h3FF0000000000000, 64'h4000000000000000, 5'd17, 64'd0, 1'b0, 1'b1);
        apply_stimulus(0, MIN, 64'h0000000000000002, 64'h0000000000000001, 5'd18, 64'h0000000000000001, 1'b0, 1'b1);
        apply_stimulus(0, MAX, 64'h7FF4000000000000, 64'h7FF0000000000001, 5'd19, 64'h7FF8000000000000, 1'b1, 1'b1);
        wait_drain("drain_directed");

        // Tagged stream under random back-pressure: even MIN -> a, odd MAX -> b.
        rand_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0)
                apply_stimulus(0, MIN, 64'h3FF0000000000000 + 64'(i), 64'h4000000000000000, 5'(i),
                               64'h3FF0000000000000 + 64'(i), 1'b0, 1'b1);
            else
                apply_stimulus(0, MAX, 64'h3FF0000000000000 + 64'(i), 64'h4000000000000000, 5'(i),
                               64'h4000000000000000, 1'b0, 1'b1);
        end
        wait_drain("drain_stream");
        rand_ready = 1'b0;
        ifd.out_ready = 1'b1;
        ifs.out_ready = 1'b1;

        // Fill with consumer stalled: two ops fill LAT=2 stages, then in_ready drops.
        ifd.out_ready = 1'b0;
        apply_stimulus(0, MAX, 64'h3FF0000000000000, 64'h4000000000000000, 5'd20, 64'h4000000000000000, 1'b0, 1'b1);
        apply_stimulus(0, MIN, 64'h3FF0000000000000, 64'h4000000000000000, 5'd21, 64'h3FF0000000000000, 1'b0, 1'b1);
        @(negedge clk);
        check_output("fill_in_ready", 64'(ifd.in_ready), 64'd0);
        @(negedge clk);
        @(posedge clk);
        #1;
        ifd.out_ready = 1'b1;
        wait_drain("drain_fill");

        // Reset with two ops in flight; nothing may come out afterwards.
        ifd.out_ready = 1'b0;
        apply_stimulus(0, MIN, 64'h3FF0000000000000, 64'h4000000000000000, 5'd22, 64'd0, 1'b0, 1'b0);
        apply_stimulus(0, MIN, 64'h3FF0000000000000, 64'h4000000000000000, 5'd23, 64'd0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("inflight_reset_valid", 64'(ifd.out_valid), 64'd0);
        check_output("inflight_reset_result", ifd.out_result, 64'd0);
        check_output("inflight_reset_nv_tag", {58'd0, ifd.out_nv, ifd.out_tag}, 64'd0);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        ifd.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check_output("in_ready_after_pulse", 64'(ifd.in_ready), 64'd1);
        repeat (6) @(posedge clk);
        #1;

        // Single precision instance.
        apply_stimulus(1, MIN, 64'h3F800000, 64'h40000000, 5'd24, 64'h3F800000, 1'b0, 1'b1);
        apply_stimulus(1, MAX, 64'h7FC00000, 64'h7FC00000, 5'd25, 64'h7FC00000, 1'b0, 1'b1);
        apply_stimulus(1, MAX, 64'h7F800001, 64'h7FA00000, 5'd26, 64'h7FC00000, 1'b1, 1'b1);
        apply_stimulus(1, FLT, 64'hBF800000, 64'h3F800000, 5'd27, 64'd1, 1'b0, 1'b1);
        apply_stimulus(1, FLE, 64'h7F800000, 64'h7F800000, 5'd28, 64'd1, 1'b0, 1'b1);
        apply_stimulus(1, MIN, 64'h80000000, 64'h00000000, 5'd29, 64'h80000000, 1'b0, 1'b1);
        wait_drain("drain_single");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
